alt_trigout_ts_fifo: RTL
========================

# alt_trigout_ts_fifo

Trigger timestamp buffer for the alternate trigger-out path. Samples the per-channel and external trigger pulses together with the White Rabbit timebase, then coalesces same-cycle triggers into one entry with a channel mask. Entries go into a first-word-fall-through FIFO. The head entry drives the timestamp/mask inputs of the trigout register block, which pops one entry per read of its cycles register.

## Interface
Parameters:
- `DEPTH`, default 16: number of FIFO entries; power of two, 2..256.

Ports:
- `clk_i`  in  1  system clock; the only clock.
- `rst_n_i`  in  1  reset; asynchronous, active-low.
- `ch1_trig_i` .. `ch4_trig_i`  in  1 each  single-cycle trigger pulse, channels 1-4.
- `ext_trig_i`  in  1  single-cycle external trigger pulse.
- `ch1_enable_i` .. `ch4_enable_i`, `ext_enable_i`  in  1 each  trigger enables from the ctrl register.
- `tai_sec_i`  in  40  WR seconds.
- `tai_cycles_i`  in  28  WR sub-second cycle counter.
- `ts_present_o`  out  1  FIFO not empty.
- `ts_sec_o`  out  40  head entry seconds.
- `cycles_o`  out  28  head entry cycles.
- `ch1_mask_o` .. `ch4_mask_o`, `ext_mask_o`  out  1 each  head entry trigger mask.
- `ts_cycles_rd_i`  in  1  pop strobe; one-cycle pulse per read.
- `overflow_o`  out  1  sticky: an entry was dropped.
- `drop_cnt_o`  out  16  saturating count of dropped entries.
- `overflow_clr_i`  in  1  clears `overflow_o` and `drop_cnt_o`.

## Operation
- Entry format, 73 bits: {ext, ch4..ch1 mask, sec[39:0], cycles[27:0]}.
- Capture stage:
  - On each edge, gated mask = trig & enable per source is registered together with `tai_sec_i`/`tai_cycles_i` from the same cycle.
  - `cap_valid` = OR of the gated mask.
  - Disabled sources are never recorded.
- Same-cycle triggers on several sources form one entry with several mask bits set.
- Write stage: a valid capture is written at the next edge if accepted.
  - Accepted if count < DEPTH, or if count = DEPTH and a pop occurs in the same cycle.
- Pop: `ts_cycles_rd_i` with count > 0 advances the read pointer at the edge. A pop with count = 0 is ignored, with no underflow.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Head outputs: read asynchronously from the read-pointer location. All head outputs are forced to 0 when count = 0.
- Pointers: log2(DEPTH)-bit, wrap modulo DEPTH. Count is log2(DEPTH)+1 bits, range 0..DEPTH.
- Drop (valid capture not accepted):
  - Entry discarded; `overflow_o` set; `drop_cnt_o` incremented, saturating at 0xFFFF.
  - Drop coincident with `overflow_clr_i`: flag stays 1 and counter becomes 1.
  - Clear alone: flag 0, counter 0.
- Reset, asserted at any time including mid-operation:
  - Pointers, count, capture stage, `overflow_o` and `drop_cnt_o` go to 0.
  - All outputs read 0.
  - In-flight captures are lost.

## Timing
- Trigger in cycle N: registered at edge N+1, written at edge N+2.
- `ts_present_o` and head outputs reflect the entry from cycle N+2. Trigger-to-present latency is 2 cycles.
- Timestamp recorded is the `tai_*` value present in cycle N.
- The consumer samples head outputs combinationally in the same cycle as `ts_cycles_rd_i`. Pop takes effect at that edge, so the next entry or an empty FIFO is visible in the following cycle.
- Back-to-back triggers every cycle are sustained: one write per cycle.
- `overflow_o` and `drop_cnt_o` update at the write-stage edge of the dropped entry (N+2).
- `ts_present_o` falls in the cycle after the pop of the last entry.

## Test plan
- Reset, no triggers:
  - `ts_present_o`=0, all head outputs 0, `drop_cnt_o`=0.
  - Pop while empty: still 0.
- Single trigger, ch2 enabled, `tai_sec`=0x12_3456_789A, `tai_cycles`=0x0ABCDEF in the trigger cycle:
  - 2 cycles later `ts_present_o`=1 with those values and only `ch2_mask_o`=1.
  - Pop: `ts_present_o`=0 next cycle.
- ch1 and ext pulsed in the same cycle, ch3 pulsed with `ch3_enable_i`=0:
  - One entry with ch1 and ext masks set, ch3 mask 0.
  - ch3 pulsed alone while disabled: no entry.
- Fill with 16 entries (DEPTH=16), then one more trigger:
  - Count 16, `overflow_o`=1, `drop_cnt_o`=1.
  - Head is still entry 0.
  - Pops return entries 0..15 in order with pointer wrap verified.
- With FIFO full, trigger such that its write edge coincides with a pop:
  - Entry accepted, no drop, count stays 16.
- `overflow_clr_i` in the same cycle as a drop: `overflow_o`=1, `drop_cnt_o`=1.
- `rst_n_i` asserted asynchronously with 5 entries queued: outputs go to 0 immediately and the FIFO is empty after release.

Source files
------------

// File: rtl/alt_trigout_ts_fifo.sv
// Trigger timestamp buffer: captures gated trigger masks with the WR timebase and queues them
// in a first-word-fall-through FIFO whose head feeds the trigout register block.
module alt_trigout_ts_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        ch1_trig_i,
    input  logic        ch2_trig_i,
    input  logic        ch3_trig_i,
    input  logic        ch4_trig_i,
    input  logic        ext_trig_i,
    input  logic        ch1_enable_i,
    input  logic        ch2_enable_i,
    input  logic        ch3_enable_i,
    input  logic        ch4_enable_i,
    input  logic        ext_enable_i,
    input  logic [39:0] tai_sec_i,
    input  logic [27:0] tai_cycles_i,
    output logic        ts_present_o,
    output logic [39:0] ts_sec_o,
    output logic [27:0] cycles_o,
    output logic        ch1_mask_o,
    output logic        ch2_mask_o,
    output logic        ch3_mask_o,
    output logic        ch4_mask_o,
    output logic        ext_mask_o,
    input  logic        ts_cycles_rd_i,
    output logic        overflow_o,
    output logic [15:0] drop_cnt_o,
    input  logic        overflow_clr_i
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FullCnt = DEPTH[AW:0];

    logic [4:0]    cap_mask_d, cap_mask_q;
    logic [39:0]   cap_sec_d, cap_sec_q;
    logic [27:0]   cap_cyc_d, cap_cyc_q;
    logic [AW-1:0] wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
    logic [AW:0]   count_d, count_q;
    logic          overflow_d, overflow_q;
    logic [15:0]   drop_cnt_d, drop_cnt_q;
    logic [72:0]   mem_q [DEPTH];
    logic [72:0]   head;
    logic          cap_valid, push, pop, drop, empty;

    assign cap_valid = |cap_mask_q;
    assign empty     = (count_q == '0);
    assign pop       = ts_cycles_rd_i && !empty;
    // A full FIFO still accepts when the head leaves on the same edge.
    assign push      = cap_valid && ((count_q != FullCnt) || pop);
    assign drop      = cap_valid && !push;

    always_comb begin
        cap_mask_d = {ext_trig_i & ext_enable_i, ch4_trig_i & ch4_enable_i,
                      ch3_trig_i & ch3_enable_i, ch2_trig_i & ch2_enable_i,
                      ch1_trig_i & ch1_enable_i};
        cap_sec_d  = tai_sec_i;
        cap_cyc_d  = tai_cycles_i;
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (overflow_clr_i) begin
                drop_cnt_d = 16'd1;
            end else if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end else if (overflow_clr_i) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cap_mask_q <= '0;
            cap_sec_q  <= '0;
            cap_cyc_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            cap_mask_q <= cap_mask_d;
            cap_sec_q  <= cap_sec_d;
            cap_cyc_q  <= cap_cyc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cap_mask_q, cap_sec_q, cap_cyc_q};
        end
    end

    always_comb begin
        head = empty ? '0 : mem_q[rd_ptr_q];
    end

    assign ts_present_o = !empty;
    assign ext_mask_o   = head[72];
    assign ch4_mask_o   = head[71];
    assign ch3_mask_o   = head[70];
    assign ch2_mask_o   = head[69];
    assign ch1_mask_o   = head[68];
    assign ts_sec_o     = head[67:28];
    assign cycles_o     = head[27:0];
    assign overflow_o   = overflow_q;
    assign drop_cnt_o   = drop_cnt_q;

endmodule
